uart_cmd_framer: RTL and testbench

//  Host-side command framer, one stage upstream of the system's UART RX input.
//  - Turns a parallel command request into the byte frames the system controller decodes.
//  - Hands the bytes to a UART transmitter.
//  - Collects the 1- or 2-byte response returned on the system's UART TX and flags a timeout if the response does not arrive.

---
 rtl/uart_cmd_framer.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_cmd_framer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer
// Host-side command framer: serialises a parallel command request into the
// byte frame the system controller decodes, hands the bytes to a UART
// transmitter, then collects the 1- or 2-byte response (or flags a timeout).
// Optional feature macro: FRAMER_STRAY_CNT_EN adds a saturating STRAY_CNT
// output that counts response bytes arriving when none is expected.
module uart_cmd_framer #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    CMD_VLD,
   output logic                    CMD_RDY,
   input  logic [1:0]              CMD_TYPE,
   input  logic [ADDR_WIDTH-1:0]   CMD_ADDR,
   input  logic [DATA_WIDTH-1:0]   CMD_DATA,
   input  logic [DATA_WIDTH-1:0]   CMD_OPB,
   input  logic [3:0]              CMD_FUN,
   output logic [DATA_WIDTH-1:0]   TX_BYTE,
   output logic                    TX_VLD,
   input  logic                    TX_RDY,
   input  logic [DATA_WIDTH-1:0]   RX_BYTE,
   input  logic                    RX_VLD,
   output logic [2*DATA_WIDTH-1:0] RSP_DATA,
   output logic                    RSP_VLD,
   output logic                    RSP_TIMEOUT,
`ifdef FRAMER_STRAY_CNT_EN
   output logic [7:0]              STRAY_CNT,
`endif
   output logic                    BUSY
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   // The timeout fires on the edge where the counter would step onto TIMEOUT_CYCLES-1
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

   localparam logic [1:0] CMD_RF_WR   = 2'b00;
   localparam logic [1:0] CMD_RF_RD   = 2'b01;
   localparam logic [1:0] CMD_ALU_OP  = 2'b10;
   localparam logic [1:0] CMD_ALU_NOP = 2'b11;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND     = 2'd1,
      WAIT_RSP = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_nxt;

   logic [1:0]              cmd_type_q;
   logic [ADDR_WIDTH-1:0]   cmd_addr_q;
   logic [DATA_WIDTH-1:0]   cmd_data_q;
   logic [DATA_WIDTH-1:0]   cmd_opb_q;
   logic [3:0]              cmd_fun_q;
   logic [1:0]              byte_idx;
   logic                    rx_cnt;
   logic [DATA_WIDTH-1:0]   rsp_lo;
   logic [CNT_W-1:0]        to_cnt;

   logic                    accept;
   logic                    tx_fire;
   logic                    last_tx;
   logic                    rx_take;
   logic                    rsp_done;
   logic                    time_hit;
   logic [1:0]              last_idx;
   logic [1:0]              rsp_need;

   // Byte number idx of the frame for a given command
   function automatic logic [DATA_WIDTH-1:0] frame_byte(
      input logic [1:0]            kind,
      input logic [ADDR_WIDTH-1:0] addr,
      input logic [DATA_WIDTH-1:0] data,
      input logic [DATA_WIDTH-1:0] opb,
      input logic [3:0]            fun,
      input logic [1:0]            idx
   );
      logic [DATA_WIDTH-1:0] b;
      b = '0;
      case (kind)
         CMD_RF_WR: begin
            case (idx)
               2'd0:    b = DATA_WIDTH'(8'hAA);
               2'd1:    b = DATA_WIDTH'(addr);
               default: b = data;
            endcase
         end
         CMD_RF_RD: begin
            case (idx)
               2'd0:    b = DATA_WIDTH'(8'hBB);
               default: b = DATA_WIDTH'(addr);
            endcase
         end
         CMD_ALU_OP: begin
            case (idx)
               2'd0:    b = DATA_WIDTH'(8'hCC);
               2'd1:    b = data;
               2'd2:    b = opb;
               default: b = DATA_WIDTH'(fun);
            endcase
         end
         default: begin
            case (idx)
               2'd0:    b = DATA_WIDTH'(8'hDD);
               default: b = DATA_WIDTH'(fun);
            endcase
         end
      endcase
      return b;
   endfunction

   // State register
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state selection: IDLE -> SEND -> (WAIT_RSP) -> IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) state_nxt = SEND;
         end
         SEND: begin
            if (last_tx) state_nxt = (rsp_need == 2'd0) ? IDLE : WAIT_RSP;
         end
         WAIT_RSP: begin
            if (rsp_done || time_hit) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs, frame shape of the captured command, and per-cycle strobes
   always_comb begin
      CMD_RDY  = (state == IDLE);
      BUSY     = (state != IDLE);
      last_idx = 2'd1;
      rsp_need = 2'd2;
      case (cmd_type_q)
         CMD_RF_WR:  begin last_idx = 2'd2; rsp_need = 2'd0; end
         CMD_RF_RD:  begin last_idx = 2'd1; rsp_need = 2'd1; end
         CMD_ALU_OP: begin last_idx = 2'd3; rsp_need = 2'd2; end
         default:    begin last_idx = 2'd1; rsp_need = 2'd2; end
      endcase
      accept   = (state == IDLE) && CMD_VLD;
      tx_fire  = (state == SEND) && TX_VLD && TX_RDY;
      last_tx  = tx_fire && (byte_idx == last_idx);
      rx_take  = (state == WAIT_RSP) && RX_VLD;
      rsp_done = rx_take && (({1'b0, rx_cnt} + 2'd1) == rsp_need);
      time_hit = (state == WAIT_RSP) && !RX_VLD && (to_cnt == TO_LAST);
   end

   // Command capture, registered TX byte stream, response assembly and timeout counting
   always_ff @(posedge CLK) begin
      if (!RST) begin
         cmd_type_q  <= '0;
         cmd_addr_q  <= '0;
         cmd_data_q  <= '0;
         cmd_opb_q   <= '0;
         cmd_fun_q   <= '0;
         byte_idx    <= '0;
         rx_cnt      <= 1'b0;
         rsp_lo      <= '0;
         to_cnt      <= '0;
         TX_BYTE     <= '0;
         TX_VLD      <= 1'b0;
         RSP_DATA    <= '0;
         RSP_VLD     <= 1'b0;
         RSP_TIMEOUT <= 1'b0;
      end else begin
         RSP_VLD     <= 1'b0;
         RSP_TIMEOUT <= 1'b0;
         if (accept) begin
            cmd_type_q <= CMD_TYPE;
            cmd_addr_q <= CMD_ADDR;
            cmd_data_q <= CMD_DATA;
            cmd_opb_q  <= CMD_OPB;
            cmd_fun_q  <= CMD_FUN;
            byte_idx   <= 2'd0;
            TX_BYTE    <= frame_byte(CMD_TYPE, CMD_ADDR, CMD_DATA, CMD_OPB, CMD_FUN, 2'd0);
            TX_VLD     <= 1'b1;
         end
         if (tx_fire) begin
            if (last_tx) begin
               TX_VLD <= 1'b0;
               to_cnt <= '0;
               rx_cnt <= 1'b0;
            end else begin
               byte_idx <= byte_idx + 2'd1;
               TX_BYTE  <= frame_byte(cmd_type_q, cmd_addr_q, cmd_data_q, cmd_opb_q,
                                      cmd_fun_q, byte_idx + 2'd1);
            end
         end
         if (rx_take) begin
            to_cnt <= '0;
            if (rsp_done) begin
               RSP_DATA <= rx_cnt ? {RX_BYTE, rsp_lo} : {{DATA_WIDTH{1'b0}}, RX_BYTE};
               RSP_VLD  <= 1'b1;
            end else begin
               rsp_lo <= RX_BYTE;
               rx_cnt <= 1'b1;
            end
         end else if (time_hit) begin
            RSP_TIMEOUT <= 1'b1;
         end else if (state == WAIT_RSP) begin
            to_cnt <= to_cnt + 1'b1;
         end
      end
   end

`ifdef FRAMER_STRAY_CNT_EN
   // Saturating count of response bytes that arrive while no response is awaited
   always_ff @(posedge CLK) begin
      if (!RST) begin
         STRAY_CNT <= 8'h00;
      end else if (RX_VLD && (state != WAIT_RSP) && (STRAY_CNT != 8'hFF)) begin
         STRAY_CNT <= STRAY_CNT + 8'h01;
      end
   end
`endif

endmodule

// File: tb/tb_uart_cmd_framer.sv
// tb_uart_cmd_framer
// Self-checking bench for uart_cmd_framer: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based behavioural model. Honours FRAMER_STRAY_CNT_EN when defined.
`timescale 1ns/1ps
module tb_uart_cmd_framer;

   localparam int T = 16;

   logic        CLK;
   logic        RST;
   logic        CMD_VLD;
   logic        CMD_RDY;
   logic [1:0]  CMD_TYPE;
   logic [3:0]  CMD_ADDR;
   logic [7:0]  CMD_DATA;
   logic [7:0]  CMD_OPB;
   logic [3:0]  CMD_FUN;
   logic [7:0]  TX_BYTE;
   logic        TX_VLD;
   logic        TX_RDY;
   logic [7:0]  RX_BYTE;
   logic        RX_VLD;
   logic [15:0] RSP_DATA;
   logic        RSP_VLD;
   logic        RSP_TIMEOUT;
   logic        BUSY;
`ifdef FRAMER_STRAY_CNT_EN
   logic [7:0]  STRAY_CNT;
`endif

   int check_count = 0;
   int fail_count  = 0;
   logic chk_en    = 1'b0;

   // Behavioural model: bytes still to send, bytes received, absolute timeout edge
   logic [7:0]  m_txq[$];
   logic [7:0]  m_rxq[$];
   int          m_need     = 0;
   logic        m_wait     = 1'b0;
   int          m_deadline = 0;
   logic [15:0] m_rsp_data = 16'h0000;
   logic        m_rsp_vld  = 1'b0;
   logic        m_timeout  = 1'b0;
   int          m_stray    = 0;
   int          edge_num   = 0;

   logic        exp_idle;
   logic [7:0]  t3_bytes [4];

   uart_cmd_framer #(
      .DATA_WIDTH     (8),
      .ADDR_WIDTH     (4),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .CMD_VLD     (CMD_VLD),
      .CMD_RDY     (CMD_RDY),
      .CMD_TYPE    (CMD_TYPE),
      .CMD_ADDR    (CMD_ADDR),
      .CMD_DATA    (CMD_DATA),
      .CMD_OPB     (CMD_OPB),
      .CMD_FUN     (CMD_FUN),
      .TX_BYTE     (TX_BYTE),
      .TX_VLD      (TX_VLD),
      .TX_RDY      (TX_RDY),
      .RX_BYTE     (RX_BYTE),
      .RX_VLD      (RX_VLD),
      .RSP_DATA    (RSP_DATA),
      .RSP_VLD     (RSP_VLD),
      .RSP_TIMEOUT (RSP_TIMEOUT),
`ifdef FRAMER_STRAY_CNT_EN
      .STRAY_CNT   (STRAY_CNT),
`endif
      .BUSY        (BUSY)
   );

   // Free-running clock
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // One comparison; X/Z on the DUT side counts as a failure
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs, let the next rising edge sample them, return at the falling edge
   task automatic applyStimulus(input logic rst_n, input logic cmd_vld, input logic [1:0] kind,
                                input logic [3:0] addr, input logic [7:0] data,
                                input logic [7:0] opb, input logic [3:0] fun,
                                input logic tx_rdy, input logic rx_vld, input logic [7:0] rx_byte);
      RST      = rst_n;
      CMD_VLD  = cmd_vld;
      CMD_TYPE = kind;
      CMD_ADDR = addr;
      CMD_DATA = data;
      CMD_OPB  = opb;
      CMD_FUN  = fun;
      TX_RDY   = tx_rdy;
      RX_VLD   = rx_vld;
      RX_BYTE  = rx_byte;
      @(negedge CLK);
   endtask

   task automatic idleCycle(input logic tx_rdy, input logic rx_vld, input logic [7:0] rx_byte);
      applyStimulus(1'b1, 1'b0, 2'b00, 4'h0, 8'h00, 8'h00, 4'h0, tx_rdy, rx_vld, rx_byte);
   endtask

   // Advance the model by one rising edge from the inputs sampled at that edge
   task automatic modelStep();
      logic       was_wait;
      logic       was_idle;
      logic [7:0] popped;
      edge_num++;
      if (RST !== 1'b1) begin
         m_txq.delete();
         m_rxq.delete();
         m_need     = 0;
         m_wait     = 1'b0;
         m_rsp_data = 16'h0000;
         m_rsp_vld  = 1'b0;
         m_timeout  = 1'b0;
         m_stray    = 0;
      end else begin
         m_rsp_vld = 1'b0;
         m_timeout = 1'b0;
         was_wait  = m_wait;
         was_idle  = (m_txq.size() == 0) && !m_wait;
         if (RX_VLD) begin
            if (was_wait) begin
               m_rxq.push_back(RX_BYTE);
               if (m_rxq.size() == m_need) begin
                  m_rsp_data = (m_need == 1) ? {8'h00, m_rxq[0]} : {m_rxq[1], m_rxq[0]};
                  m_rsp_vld  = 1'b1;
                  m_wait     = 1'b0;
               end else begin
                  m_deadline = edge_num + T - 1;
               end
            end else if (m_stray < 255) begin
               m_stray++;
            end
         end else if (was_wait && (edge_num == m_deadline)) begin
            m_timeout = 1'b1;
            m_wait    = 1'b0;
         end
         if (m_txq.size() > 0) begin
            if (TX_RDY) begin
               popped = m_txq.pop_front();
               if ((m_txq.size() == 0) && (m_need > 0)) begin
                  m_wait = 1'b1;
                  m_rxq.delete();
                  m_deadline = edge_num + T - 1;
               end
            end
         end else if (was_idle && CMD_VLD) begin
            case (CMD_TYPE)
               2'b00: begin
                  m_txq.push_back(8'hAA);
                  m_txq.push_back({4'h0, CMD_ADDR});
                  m_txq.push_back(CMD_DATA);
                  m_need = 0;
               end
               2'b01: begin
                  m_txq.push_back(8'hBB);
                  m_txq.push_back({4'h0, CMD_ADDR});
                  m_need = 1;
               end
               2'b10: begin
                  m_txq.push_back(8'hCC);
                  m_txq.push_back(CMD_DATA);
                  m_txq.push_back(CMD_OPB);
                  m_txq.push_back({4'h0, CMD_FUN});
                  m_need = 2;
               end
               default: begin
                  m_txq.push_back(8'hDD);
                  m_txq.push_back({4'h0, CMD_FUN});
                  m_need = 2;
               end
            endcase
         end
      end
   endtask

   // Model process
   initial begin
      forever begin
         @(posedge CLK);
         modelStep();
      end
   end

   // Compare process: every falling edge once checking is enabled
   initial begin
      forever begin
         @(negedge CLK);
         if (chk_en) begin
            exp_idle = (m_txq.size() == 0) && !m_wait;
            checkOutput("cmd_rdy", 32'(CMD_RDY), 32'(exp_idle));
            checkOutput("busy", 32'(BUSY), 32'(!exp_idle));
            checkOutput("tx_vld", 32'(TX_VLD), 32'(m_txq.size() > 0));
            if (m_txq.size() > 0) checkOutput("tx_byte", 32'(TX_BYTE), 32'(m_txq[0]));
            checkOutput("rsp_vld", 32'(RSP_VLD), 32'(m_rsp_vld));
            checkOutput("rsp_timeout", 32'(RSP_TIMEOUT), 32'(m_timeout));
            checkOutput("rsp_data", 32'(RSP_DATA), 32'(m_rsp_data));
`ifdef FRAMER_STRAY_CNT_EN
            checkOutput("stray_cnt", 32'(STRAY_CNT), 32'(m_stray));
`endif
         end
      end
   end

   // Directed scenarios followed by randomized traffic
   initial begin
      t3_bytes[0] = 8'hCC;
      t3_bytes[1] = 8'h10;
      t3_bytes[2] = 8'h20;
      t3_bytes[3] = 8'h00;

      applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00);
      chk_en = 1'b1;
      applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00);
      checkOutput("rst_cmd_rdy", 32'(CMD_RDY), 'h1);
      checkOutput("rst_busy", 32'(BUSY), 'h0);
      checkOutput("rst_tx_vld", 32'(TX_VLD), 'h0);
      checkOutput("rst_tx_byte", 32'(TX_BYTE), 'h0);
      checkOutput("rst_rsp_data", 32'(RSP_DATA), 'h0);
      checkOutput("rst_rsp_vld", 32'(RSP_VLD), 'h0);
      checkOutput("rst_timeout", 32'(RSP_TIMEOUT), 'h0);

      // RF_WR addr=3 data=0x5A, back-to-back bytes
      applyStimulus(1'b1, 1'b1, 2'b00, 4'd3, 8'h5A, 8'h00, 4'h0, 1'b1, 1'b0, 8'h00);
      checkOutput("t1_byte0", 32'(TX_BYTE), 'hAA);
      checkOutput("t1_vld0", 32'(TX_VLD), 'h1);
      checkOutput("t1_rdy_low", 32'(CMD_RDY), 'h0);
      idleCycle(1'b1, 1'b0, 8'h00);
      checkOutput("t1_byte1", 32'(TX_BYTE), 'h03);
      idleCycle(1'b1, 1'b0, 8'h00);
      checkOutput("t1_byte2", 32'(TX_BYTE), 'h5A);
      idleCycle(1'b1, 1'b0, 8'h00);
      checkOutput("t1_cmd_rdy", 32'(CMD_RDY), 'h1);
      checkOutput("t1_tx_done", 32'(TX_VLD), 'h0);
      checkOutput("t1_no_rsp", 32'(RSP_VLD), 'h0);

      // RF_RD addr=2, single response byte 0x81
      applyStimulus(1'b1, 1'b1, 2'b01, 4'd2, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 8'h00);
      checkOutput("t2_byte0", 32'(TX_BYTE), 'hBB);
      idleCycle(1'b1, 1'b0, 8'h00);
      checkOutput("t2_byte1", 32'(TX_BYTE), 'h02);
      idleCycle(1'b1, 1'b0, 8'h00);
      checkOutput("t2_waiting", 32'(BUSY), 'h1);
      idleCycle(1'b1, 1'b1, 8'h81);
      checkOutput("t2_rsp_vld", 32'(RSP_VLD), 'h1);
      checkOutput("t2_rsp_data", 32'(RSP_DATA), 'h0081);
      checkOutput("t2_busy", 32'(BUSY), 'h0);
      idleCycle(1'b1, 1'b0, 8'h00);
      checkOutput("t2_vld_pulse", 32'(RSP_VLD), 'h0);

      // ALU_OP with TX_RDY alternating 0/1
      applyStimulus(1'b1, 1'b1, 2'b10, 4'h0, 8'h10, 8'h20, 4'h0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 4; i++) begin
         idleCycle(1'b0, 1'b0, 8'h00);
         checkOutput("t3_hold", 32'(TX_BYTE), 32'(t3_bytes[i]));
         checkOutput("t3_hold_vld", 32'(TX_VLD), 'h1);
         idleCycle(1'b1, 1'b0, 8'h00);
         if (i < 3) checkOutput("t3_next", 32'(TX_BYTE), 32'(t3_bytes[i + 1]));
      end
      checkOutput("t3_tx_done", 32'(TX_VLD), 'h0);
      idleCycle(1'b1, 1'b1, 8'h30);
      checkOutput("t3_partial", 32'(RSP_VLD), 'h0);
      idleCycle(1'b1, 1'b1, 8'h00);
      checkOutput("t3_rsp_vld", 32'(RSP_VLD), 'h1);
      checkOutput("t3_rsp_data", 32'(RSP_DATA), 'h0030);

      // ALU_NOP FUN=1 with no response: timeout T-1 edges after the last transfer
      applyStimulus(1'b1, 1'b1, 2'b11, 4'h0, 8'h00, 8'h00, 4'h1, 1'b1, 1'b0, 8'h00);
      checkOutput("t4_byte0", 32'(TX_BYTE), 'hDD);
      idleCycle(1'b1, 1'b0, 8'h00);
      checkOutput("t4_byte1", 32'(TX_BYTE), 'h01);
      idleCycle(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < T - 2; i++) begin
         idleCycle(1'b1, 1'b0, 8'h00);
         checkOutput("t4_early", 32'(RSP_TIMEOUT), 'h0);
      end
      idleCycle(1'b1, 1'b0, 8'h00);
      checkOutput("t4_timeout", 32'(RSP_TIMEOUT), 'h1);
      checkOutput("t4_rsp_kept", 32'(RSP_DATA), 'h0030);
      checkOutput("t4_cmd_rdy", 32'(CMD_RDY), 'h1);
      idleCycle(1'b1, 1'b0, 8'h00);
      checkOutput("t4_to_pulse", 32'(RSP_TIMEOUT), 'h0);

      // RX byte on the terminal timeout edge wins and restarts the counter
      applyStimulus(1'b1, 1'b1, 2'b11, 4'h0, 8'h00, 8'h00, 4'h2, 1'b1, 1'b0, 8'h00);
      idleCycle(1'b1, 1'b0, 8'h00);
      idleCycle(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < T - 2; i++) idleCycle(1'b1, 1'b0, 8'h00);
      idleCycle(1'b1, 1'b1, 8'h44);
      checkOutput("t5_no_timeout", 32'(RSP_TIMEOUT), 'h0);
      checkOutput("t5_still_busy", 32'(BUSY), 'h1);
      for (int i = 0; i < T - 2; i++) idleCycle(1'b1, 1'b0, 8'h00);
      checkOutput("t5_restarted", 32'(BUSY), 'h1);
      idleCycle(1'b1, 1'b1, 8'h55);
      checkOutput("t5_rsp_vld", 32'(RSP_VLD), 'h1);
      checkOutput("t5_rsp_data", 32'(RSP_DATA), 'h5544);

      // Reset mid-frame, then a stray byte in IDLE
      applyStimulus(1'b1, 1'b1, 2'b00, 4'd7, 8'h11, 8'h00, 4'h0, 1'b1, 1'b0, 8'h00);
      idleCycle(1'b1, 1'b0, 8'h00);
      checkOutput("t6_byte1", 32'(TX_BYTE), 'h07);
      applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 8'h00);
      checkOutput("t6_tx_abort", 32'(TX_VLD), 'h0);
      checkOutput("t6_idle", 32'(CMD_RDY), 'h1);
      idleCycle(1'b1, 1'b1, 8'h77);
      checkOutput("t6_rsp_kept", 32'(RSP_DATA), 'h0000);
      checkOutput("t6_no_vld", 32'(RSP_VLD), 'h0);
      checkOutput("t6_not_busy", 32'(BUSY), 'h0);
`ifdef FRAMER_STRAY_CNT_EN
      checkOutput("t6_stray", 32'(STRAY_CNT), 'h1);
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(0, 299) != 0), ($urandom_range(0, 1) == 1),
                       2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                       8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)),
                       ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
                       8'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
      $finish;
   end

endmodule
